// File: rtl/dspba_credit_drain_if.sv
// Handshake bundle for dspba_credit_drain.
// Carries the request side, the pipeline issue/result pair and the result stream side.
// The slave modport is the drain itself. The master modport is whatever surrounds it.
interface dspba_credit_drain_if #(
  parameter int DATAW = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             pipe_issue;
  logic [DATAW-1:0] pipe_result;
  logic             out_valid;
  logic [DATAW-1:0] out_data;
  logic             out_ready;
  logic             busy;

  modport master (
    output in_valid, pipe_result, out_ready,
    input  in_ready, pipe_issue, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, pipe_result, out_ready,
    output in_ready, pipe_issue, out_valid, out_data, busy
  );
endinterface

// File: rtl/dspba_credit_drain.sv
// Credit-gated result drain for a fixed-latency, never-stalling DSPBA pipeline.
// Every issue reserves one result FIFO slot ahead of time, so the pipeline can run with ena=1.
// A result is captured LATENCY cycles after its issue and is handed out in issue order.
// A credit comes back one cycle after its result is popped.
module dspba_credit_drain #(
  parameter int DATAW   = 32,
  parameter int LATENCY = 4,
  parameter int DEPTH   = 8
) (
  input  logic                 clk,
  input  logic                 aclr,
  dspba_credit_drain_if.slave  bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0]    r_credits;
  logic [CW-1:0]    r_count;
  logic [LATENCY-1:0] r_vsr;
  logic [PW-1:0]    r_wrptr;
  logic [PW-1:0]    r_rdptr;
  logic [DATAW-1:0] r_mem [DEPTH];

  logic w_in_ready;
  logic w_issue;
  logic w_out_valid;
  logic w_pop;
  logic w_wr;

  // Circular pointer advance that also works for a DEPTH that is not a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // in_ready comes from the registered credit count only. It is gated by aclr so it reads 0 during reset.
  assign w_in_ready  = aclr & (r_credits != '0);
  assign w_issue     = bus.in_valid & w_in_ready;
  assign w_out_valid = (r_count != '0);
  assign w_pop       = w_out_valid & bus.out_ready;
  // The oldest tracker bit marks the cycle in which pipe_result holds a live result.
  assign w_wr        = r_vsr[LATENCY-1];

  assign bus.in_ready   = w_in_ready;
  assign bus.pipe_issue = w_issue;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_data   = r_mem[r_rdptr];
  assign bus.busy       = (r_vsr != '0) | w_out_valid;

  // Credit counter: an issue takes a credit, a pop gives one back.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      r_credits <= CW'(DEPTH);
    end else begin
      case ({w_issue, w_pop})
        2'b10:   r_credits <= r_credits - 1'b1;
        2'b01:   r_credits <= r_credits + 1'b1;
        default: r_credits <= r_credits;
      endcase
    end
  end

  // In-flight tracker. It mirrors the pipeline's valid path and shifts every cycle.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      r_vsr <= '0;
    end else begin
      r_vsr[0] <= w_issue;
      for (int i = 1; i < LATENCY; i++) begin
        r_vsr[i] <= r_vsr[i-1];
      end
    end
  end

  // FIFO control: occupancy and the circular read/write pointers.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      r_count <= '0;
      r_wrptr <= '0;
      r_rdptr <= '0;
    end else begin
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_wr) begin
        r_wrptr <= ptr_inc(r_wrptr);
      end
      if (w_pop) begin
        r_rdptr <= ptr_inc(r_rdptr);
      end
    end
  end

  // FIFO storage. This is data only, so it has no reset. Stale entries sit behind a zero count.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wrptr] <= bus.pipe_result;
    end
  end

  // The checks below cover cases that the credit scheme should make impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!aclr)
    !(w_wr && (r_count == CW'(DEPTH))));
  a_credit_max: assert property (@(posedge clk) disable iff (!aclr)
    (r_credits <= CW'(DEPTH)));
  a_credit_under: assert property (@(posedge clk) disable iff (!aclr)
    !(w_issue && (r_credits == '0)));
  a_conserve: assert property (@(posedge clk) disable iff (!aclr)
    ((32'(r_credits) + 32'($countones(r_vsr)) + 32'(r_count)) == DEPTH));

endmodule

// File: tb/tb_dspba_credit_drain.sv
// Bench for dspba_credit_drain.
// Three instances share clk and aclr: (L4,D8), (L4,D5) and (L4,D2).
// Each pipeline is modelled as an ena=1 delay line that carries the operand (a sequence id).
// A request costs one credit from issue until the cycle after its pop, which is LATENCY+2 cycles.
// Issue n of an unthrottled stream therefore lands on cycle (L+2)*(n/D) + n%D when D <= L+2.
module tb_dspba_credit_drain;

  localparam int L = 4;
  localparam int DEP [3] = '{8, 5, 2};

  logic clk = 1'b0;
  logic aclr = 1'b0;
  always #5 clk = ~clk;

  logic        vin  [3];
  logic        ordy [3];
  logic [31:0] op   [3];
  logic [31:0] pl   [3][L];

  logic        irdy_w [3];
  logic        iss_w  [3];
  logic        ov_w   [3];
  logic        busy_w [3];
  logic [31:0] od_w   [3];

  dspba_credit_drain_if #(.DATAW(32)) if0 ();
  dspba_credit_drain_if #(.DATAW(32)) if1 ();
  dspba_credit_drain_if #(.DATAW(32)) if2 ();

  dspba_credit_drain #(.DATAW(32), .LATENCY(L), .DEPTH(8)) u_d8 (.clk(clk), .aclr(aclr), .bus(if0));
  dspba_credit_drain #(.DATAW(32), .LATENCY(L), .DEPTH(5)) u_d5 (.clk(clk), .aclr(aclr), .bus(if1));
  dspba_credit_drain #(.DATAW(32), .LATENCY(L), .DEPTH(2)) u_d2 (.clk(clk), .aclr(aclr), .bus(if2));

  assign if0.in_valid = vin[0];  assign if0.out_ready = ordy[0];  assign if0.pipe_result = pl[0][L-1];
  assign if1.in_valid = vin[1];  assign if1.out_ready = ordy[1];  assign if1.pipe_result = pl[1][L-1];
  assign if2.in_valid = vin[2];  assign if2.out_ready = ordy[2];  assign if2.pipe_result = pl[2][L-1];

  assign irdy_w[0] = if0.in_ready;   assign irdy_w[1] = if1.in_ready;   assign irdy_w[2] = if2.in_ready;
  assign iss_w[0]  = if0.pipe_issue; assign iss_w[1]  = if1.pipe_issue; assign iss_w[2]  = if2.pipe_issue;
  assign ov_w[0]   = if0.out_valid;  assign ov_w[1]   = if1.out_valid;  assign ov_w[2]   = if2.out_valid;
  assign busy_w[0] = if0.busy;       assign busy_w[1] = if1.busy;       assign busy_w[2] = if2.busy;
  assign od_w[0]   = if0.out_data;   assign od_w[1]   = if1.out_data;   assign od_w[2]   = if2.out_data;

  // Pipeline model: ena=1 delay lines that keep shifting through reset, just like the real pipelines.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      pl[k][0] <= op[k];
      for (int s = 1; s < L; s++) pl[k][s] <= pl[k][s-1];
    end
  end

  int nvec  = 0;
  int nfail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        aclr, vin, ordy;
    logic [31:0] op;
    logic        irdy, iss, ov, busy;
    logic        dchk;
    logic [31:0] data;
  } vec_t;

  vec_t tbl [11];

  // One cycle on instance 0. Inputs change just after the rising edge and are sampled at the falling edge.
  task automatic cyc0(input logic v, input logic r, input logic [31:0] o);
    @(posedge clk); #1;
    vin[0] = v; ordy[0] = r; op[0] = v ? o : 32'hBAD0_0000;
    @(negedge clk);
  endtask

  // Fill instance 0 with out_ready low, then drain it and check the order and the credit return.
  task automatic backpressure(input logic [31:0] base);
    int issued;
    issued = 0;
    for (int c = 0; c < 16; c++) begin
      cyc0(1'b1, 1'b0, base + issued);
      if (iss_w[0]) issued++;
    end
    cyc0(1'b0, 1'b0, 32'h0);
    chk("bp_issues", issued, 8);
    chk("bp_in_ready_full", irdy_w[0], 1'b0);
    chk("bp_out_valid_full", ov_w[0], 1'b1);
    chk("bp_busy_full", busy_w[0], 1'b1);
    for (int i = 0; i < 8; i++) begin
      cyc0(1'b0, 1'b1, 32'h0);
      chk($sformatf("bp_drain_valid[%0d]", i), ov_w[0], 1'b1);
      chk($sformatf("bp_drain_data[%0d]", i), od_w[0], base + i);
      if (i < 2) chk($sformatf("bp_credit_return[%0d]", i), irdy_w[0], (i == 0) ? 1'b0 : 1'b1);
    end
    cyc0(1'b0, 1'b1, 32'h0);
    chk("bp_empty_valid", ov_w[0], 1'b0);
    chk("bp_empty_busy", busy_w[0], 1'b0);
    chk("bp_empty_ready", irdy_w[0], 1'b1);
    cyc0(1'b0, 1'b0, 32'h0);
  endtask

  // Send n requests back to back with out_ready held high, and check issue timing and output order.
  task automatic stream(input int sel, input int n);
    int issued, got, cyc, first;
    issued = 0; got = 0; cyc = 0; first = -1;
    while (got < n && cyc < 2000) begin
      @(posedge clk); #1;
      vin[sel] = (issued < n); op[sel] = (issued < n) ? issued : 32'hBAD0_0000; ordy[sel] = 1'b1;
      @(negedge clk);
      if (iss_w[sel]) begin
        chk($sformatf("s%0d_issue_cycle[%0d]", sel, issued), cyc,
            (L + 2) * (issued / DEP[sel]) + (issued % DEP[sel]));
        issued++;
      end
      if (ov_w[sel]) begin
        if (first < 0) first = cyc;
        chk($sformatf("s%0d_order[%0d]", sel, got), od_w[sel], got);
        got++;
      end
      cyc++;
    end
    chk($sformatf("s%0d_received", sel), got, n);
    chk($sformatf("s%0d_first_out_cycle", sel), first, L + 1);
    @(posedge clk); #1;
    vin[sel] = 1'b0; ordy[sel] = 1'b0;
    @(negedge clk);
    chk($sformatf("s%0d_idle_busy", sel), busy_w[sel], 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin vin[k] = 1'b0; ordy[k] = 1'b0; op[k] = 32'hBAD0_0000; end

    // Reset for 3 cycles, then a single issue of 0xA5 on (L4,D8) that is popped on arrival.
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 32'hBAD0_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[1]  = tbl[0];
    tbl[2]  = tbl[0];
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'hBAD0_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 32'h0000_00A5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'hBAD0_0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[6]  = tbl[5];
    tbl[7]  = tbl[5];
    tbl[8]  = tbl[5];
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 32'hBAD0_0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_00A5};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 32'hBAD0_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};

    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      aclr = tbl[i].aclr; vin[0] = tbl[i].vin; ordy[0] = tbl[i].ordy; op[0] = tbl[i].op;
      @(negedge clk);
      chk($sformatf("v%0d_in_ready", i), irdy_w[0], tbl[i].irdy);
      chk($sformatf("v%0d_pipe_issue", i), iss_w[0], tbl[i].iss);
      chk($sformatf("v%0d_out_valid", i), ov_w[0], tbl[i].ov);
      chk($sformatf("v%0d_busy", i), busy_w[0], tbl[i].busy);
      if (tbl[i].dchk) chk($sformatf("v%0d_out_data", i), od_w[0], tbl[i].data);
    end

    backpressure(32'h0);
    stream(1, 100);
    stream(2, 20);

    // Reset mid-flight: 2 results buffered and 3 in flight, then a one-cycle aclr pulse.
    cyc0(1'b1, 1'b0, 32'd100);
    cyc0(1'b1, 1'b0, 32'd101);
    repeat (4) cyc0(1'b0, 1'b0, 32'h0);
    cyc0(1'b1, 1'b0, 32'd200);
    cyc0(1'b1, 1'b0, 32'd201);
    cyc0(1'b1, 1'b0, 32'd202);
    chk("mf_pre_valid", ov_w[0], 1'b1);
    chk("mf_pre_head", od_w[0], 32'd100);
    @(posedge clk); #1;
    vin[0] = 1'b0; aclr = 1'b0;
    @(negedge clk);
    chk("mf_rst_valid", ov_w[0], 1'b0);
    chk("mf_rst_busy", busy_w[0], 1'b0);
    chk("mf_rst_ready", irdy_w[0], 1'b0);
    chk("mf_rst_issue", iss_w[0], 1'b0);
    @(posedge clk); #1;
    aclr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc0(1'b0, 1'b1, 32'h0);
      chk($sformatf("mf_stale_valid[%0d]", i), ov_w[0], 1'b0);
      chk($sformatf("mf_stale_busy[%0d]", i), busy_w[0], 1'b0);
    end
    // All DEPTH credits must be back: exactly 8 fresh issues, drained in order.
    backpressure(32'd300);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
